inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction-fetch unit and the memory controller's fetch port.
- Serves 32-bit instruction words to fetch.
- On a miss, issues one word fetch to the memory controller and holds the request until the filled word returns.
- Invalidates all lines on reset; supports a pipeline flush that discards an in-flight miss result without corrupting the cache.

---
 rtl/inst_cache_pkg.sv | 13 +
 rtl/icache_array.sv | 55 +++++
 rtl/inst_cache.sv | 141 ++++++++++++++
 tb/tb_inst_cache.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// default widths and the controller state encoding.
package inst_cache_pkg;

    localparam int DEFAULT_XLEN        = 32;
    localparam int DEFAULT_INDEX_WIDTH = 6;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one word per line,
// combinational read, synchronous fill write, valid bits cleared on rst.
module icache_array
    import inst_cache_pkg::*;
#(
    parameter int XLEN        = DEFAULT_XLEN,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int TAG_WIDTH   = XLEN - INDEX_WIDTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [XLEN-1:0]        rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [XLEN-1:0]        wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_reg;
    logic [LINES-1:0]     line_we;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [XLEN-1:0]      data_mem [LINES];

    // Per-line fill decode; a line only ever becomes valid, never invalid, outside reset.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line_we
            assign line_we[gi] = wr_en && (wr_index == INDEX_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | line_we;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, single-word
// miss fetch to the memory controller, flush discards an in-flight fill pulse.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int XLEN        = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic            fetch_enable,
    output logic [XLEN-1:0] inst_addr,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_data
);

    localparam int TAG_WIDTH = XLEN - INDEX_WIDTH - 2;

    state_t                 state_reg, state_next;
    logic                   inst_valid_reg, inst_valid_next;
    logic [XLEN-1:0]        inst_reg, inst_next;
    logic                   fetch_enable_reg, fetch_enable_next;
    logic [XLEN-1:0]        inst_addr_reg, inst_addr_next;
    logic                   discard_reg, discard_next;
    logic [INDEX_WIDTH-1:0] miss_index_reg, miss_index_next;
    logic [TAG_WIDTH-1:0]   miss_tag_reg, miss_tag_next;

    logic [INDEX_WIDTH-1:0] pc_index;
    logic [TAG_WIDTH-1:0]   pc_tag;
    logic [XLEN-1:0]        aligned_pc;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [XLEN-1:0]        rd_data;
    logic                   hit;
    logic                   fill_en;
    logic                   wr_en;

    assign pc_index   = pc[INDEX_WIDTH+1:2];
    assign pc_tag     = pc[XLEN-1:INDEX_WIDTH+2];
    assign aligned_pc = pc & ~XLEN'(3);
    assign hit        = rd_valid && (rd_tag == pc_tag);
    // The fill must not land while frozen or while reset is clearing the valid bits.
    assign wr_en      = fill_en && rdy && !rst;

    icache_array #(
        .XLEN        (XLEN),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (miss_index_reg),
        .wr_tag   (miss_tag_reg),
        .wr_data  (mem_data)
    );

    always_comb begin
        state_next        = state_reg;
        inst_valid_next   = 1'b0;
        inst_next         = inst_reg;
        fetch_enable_next = fetch_enable_reg;
        inst_addr_next    = inst_addr_reg;
        discard_next      = discard_reg;
        miss_index_next   = miss_index_reg;
        miss_tag_next     = miss_tag_reg;
        fill_en           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pc_valid && !flush) begin
                    if (hit) begin
                        inst_valid_next = 1'b1;
                        inst_next       = rd_data;
                    end else begin
                        fetch_enable_next = 1'b1;
                        inst_addr_next    = aligned_pc;
                        miss_index_next   = pc_index;
                        miss_tag_next     = pc_tag;
                        state_next        = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_valid) begin
                    fill_en           = 1'b1;
                    fetch_enable_next = 1'b0;
                    inst_addr_next    = '0;
                    discard_next      = 1'b0;
                    state_next        = IDLE;
                    // A flush arriving with the fill still cancels the pulse.
                    if (!(discard_reg || flush)) begin
                        inst_valid_next = 1'b1;
                        inst_next       = mem_data;
                    end
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            inst_valid_reg   <= 1'b0;
            inst_reg         <= '0;
            fetch_enable_reg <= 1'b0;
            inst_addr_reg    <= '0;
            discard_reg      <= 1'b0;
            miss_index_reg   <= '0;
            miss_tag_reg     <= '0;
        end else if (rdy) begin
            state_reg        <= state_next;
            inst_valid_reg   <= inst_valid_next;
            inst_reg         <= inst_next;
            fetch_enable_reg <= fetch_enable_next;
            inst_addr_reg    <= inst_addr_next;
            discard_reg      <= discard_next;
            miss_index_reg   <= miss_index_next;
            miss_tag_reg     <= miss_tag_next;
        end
    end

    assign inst_valid   = inst_valid_reg;
    assign inst         = inst_reg;
    assign fetch_enable = fetch_enable_reg;
    assign inst_addr    = inst_addr_reg;

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache: cold miss, hit, eviction,
// flush cases, rdy stall and reset during a miss.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        pc_valid;
    logic [31:0] pc;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        fetch_enable;
    logic [31:0] inst_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    inst_cache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .flush        (flush),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .fetch_enable (fetch_enable),
        .inst_addr    (inst_addr),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string name);
        $display("txn %-18s iv=%0b inst=%08h fe=%0b addr=%08h", name, inst_valid, inst, fetch_enable, inst_addr);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; pc_valid = 1'b0; pc = '0; flush = 1'b0;
        mem_valid = 1'b0; mem_data = '0;
        tick(); tick();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_fetch_enable", 32'(fetch_enable), 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        txn("reset");
        rst = 1'b0;

        // Cold miss on 0x0, fill returned after 5 cycles
        pc_valid = 1'b1; pc = 32'h0000_0000;
        tick();
        check("cold_fe", 32'(fetch_enable), 32'd1);
        check("cold_addr", inst_addr, 32'h0);
        check("cold_no_iv", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cold_wait_fe", 32'(fetch_enable), 32'd1);
            check("cold_wait_addr", inst_addr, 32'h0);
            check("cold_wait_iv", 32'(inst_valid), 32'd0);
        end
        mem_valid = 1'b1; mem_data = 32'h0000_0513;
        tick();
        mem_valid = 1'b0;
        check("cold_fill_iv", 32'(inst_valid), 32'd1);
        check("cold_fill_inst", inst, 32'h0000_0513);
        check("cold_fill_fe", 32'(fetch_enable), 32'd0);
        check("cold_fill_addr", inst_addr, 32'h0);
        txn("cold miss");

        // Hit on the just-filled line
        tick();
        check("hit_iv", 32'(inst_valid), 32'd1);
        check("hit_inst", inst, 32'h0000_0513);
        check("hit_fe", 32'(fetch_enable), 32'd0);
        txn("hit");
        pc_valid = 1'b0;
        tick();
        check("hit_pulse_end", 32'(inst_valid), 32'd0);

        // Conflict eviction: 0x100 shares index 0 with 0x0
        pc_valid = 1'b1; pc = 32'h0000_0100;
        tick();
        check("evict_fe", 32'(fetch_enable), 32'd1);
        check("evict_addr", inst_addr, 32'h0000_0100);
        check("evict_no_iv", 32'(inst_valid), 32'd0);
        mem_valid = 1'b1; mem_data = 32'h0010_0093;
        tick();
        mem_valid = 1'b0;
        check("evict_fill_iv", 32'(inst_valid), 32'd1);
        check("evict_fill_inst", inst, 32'h0010_0093);
        txn("evict fill");
        pc = 32'h0000_0000;
        tick();
        check("remiss_fe", 32'(fetch_enable), 32'd1);
        check("remiss_addr", inst_addr, 32'h0);
        check("remiss_no_iv", 32'(inst_valid), 32'd0);
        mem_valid = 1'b1; mem_data = 32'h0000_0513;
        tick();
        mem_valid = 1'b0;
        check("remiss_fill_inst", inst, 32'h0000_0513);
        txn("re-miss 0x0");
        pc_valid = 1'b0;
        tick();

        // Flush mid-miss: fill completes but no pulse
        pc_valid = 1'b1; pc = 32'h0000_0004;
        tick();
        check("fl_fe", 32'(fetch_enable), 32'd1);
        check("fl_addr", inst_addr, 32'h0000_0004);
        tick();
        flush = 1'b1; pc_valid = 1'b0;
        tick();
        flush = 1'b0;
        check("fl_fe_held", 32'(fetch_enable), 32'd1);
        check("fl_addr_held", inst_addr, 32'h0000_0004);
        tick();
        mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_valid = 1'b0;
        check("fl_no_iv", 32'(inst_valid), 32'd0);
        check("fl_fe_drop", 32'(fetch_enable), 32'd0);
        txn("flushed fill");
        pc_valid = 1'b1; pc = 32'h0000_0004;
        tick();
        check("fl_hit_iv", 32'(inst_valid), 32'd1);
        check("fl_hit_inst", inst, 32'hDEAD_BEEF);
        check("fl_hit_fe", 32'(fetch_enable), 32'd0);
        txn("hit after flush");
        pc_valid = 1'b0;
        tick();

        // Flush coinciding with mem_valid
        pc_valid = 1'b1; pc = 32'h0000_0008;
        tick();
        check("flsame_fe", 32'(fetch_enable), 32'd1);
        pc_valid = 1'b0; flush = 1'b1; mem_valid = 1'b1; mem_data = 32'hCAFE_0001;
        tick();
        flush = 1'b0; mem_valid = 1'b0;
        check("flsame_no_iv", 32'(inst_valid), 32'd0);
        check("flsame_fe", 32'(fetch_enable), 32'd0);
        pc_valid = 1'b1; pc = 32'h0000_0008;
        tick();
        check("flsame_hit_iv", 32'(inst_valid), 32'd1);
        check("flsame_hit_inst", inst, 32'hCAFE_0001);
        txn("flush with fill");
        pc_valid = 1'b0;
        tick();

        // rdy stall while in MISS, then a held pulse across a stall
        pc_valid = 1'b1; pc = 32'h0000_000C;
        tick();
        check("rdy_fe", 32'(fetch_enable), 32'd1);
        check("rdy_addr", inst_addr, 32'h0000_000C);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_fe", 32'(fetch_enable), 32'd1);
            check("stall_addr", inst_addr, 32'h0000_000C);
            check("stall_no_iv", 32'(inst_valid), 32'd0);
        end
        rdy = 1'b1; mem_valid = 1'b1; mem_data = 32'h1234_5678;
        tick();
        mem_valid = 1'b0; pc_valid = 1'b0;
        check("rdy_fill_iv", 32'(inst_valid), 32'd1);
        check("rdy_fill_inst", inst, 32'h1234_5678);
        check("rdy_fill_fe", 32'(fetch_enable), 32'd0);
        txn("fill after stall");
        rdy = 1'b0;
        tick();
        check("pulse_held", 32'(inst_valid), 32'd1);
        rdy = 1'b1;
        tick();
        check("pulse_released", 32'(inst_valid), 32'd0);

        // Reset mid-miss abandons the miss and invalidates all lines
        pc_valid = 1'b1; pc = 32'h0000_0010;
        tick();
        check("rstm_fe", 32'(fetch_enable), 32'd1);
        rst = 1'b1; pc_valid = 1'b0;
        tick();
        check("rstm_fe_drop", 32'(fetch_enable), 32'd0);
        check("rstm_addr", inst_addr, 32'h0);
        check("rstm_iv", 32'(inst_valid), 32'd0);
        txn("reset mid-miss");
        rst = 1'b0; pc_valid = 1'b1; pc = 32'h0000_0000;
        tick();
        check("post_rst_miss_fe", 32'(fetch_enable), 32'd1);
        check("post_rst_miss_addr", inst_addr, 32'h0);
        check("post_rst_miss_iv", 32'(inst_valid), 32'd0);
        mem_valid = 1'b1; mem_data = 32'h0000_0513;
        tick();
        mem_valid = 1'b0; pc_valid = 1'b0;
        check("post_rst_fill", inst, 32'h0000_0513);
        txn("miss after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
